// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// The exception vector is only referenced when FETCH_ALIGN_CHECK_EN is defined.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0040_0000;
    localparam logic [31:0] EXC_VECTOR       = 32'h8000_0180;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO between fetch and decode.
// Flush clears pointers and count and overrides any push or pop in the same cycle.
module fetch_queue #(
    parameter int DEPTH  = 2,
    parameter int PTR_W  = $clog2(DEPTH),
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    input  logic              flush,
    output logic [DATA_W-1:0] head_data,
    output logic [PTR_W:0]    count,
    output logic              empty
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PTR_W:0]    count_reg;
    logic              do_push;
    logic              do_pop;

    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && ((count_reg != DEPTH_CNT) || do_pop);

    // Head reads zero while empty so decode never sees stale data.
    assign head_data = empty ? '0 : mem_reg[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_reg <= count_reg + (PTR_W+1)'(1);
            end else if (!do_push && do_pop) begin
                count_reg <= count_reg - (PTR_W+1)'(1);
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, BOOT/RUN/HALTED control and the fetch queue to decode.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned or null redirect targets (adds fetch_exc).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2,
    parameter int          PTR_W      = $clog2(FIFO_DEPTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic        halted
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    output logic        fetch_exc
`endif
);

    localparam logic [PTR_W:0] DEPTH_CNT = (PTR_W+1)'(FIFO_DEPTH);

    fetch_state_t   state_reg;
    fetch_state_t   state_next;
    logic [31:0]    pc_reg;
    logic [31:0]    pc_next;
    logic [31:0]    redirect_target;
    logic           push;
    logic           pop;
    logic           flush;
    logic [PTR_W:0] q_count;
    logic           q_empty;
    fetch_entry_t   push_entry;
    fetch_entry_t   head_entry;

`ifdef FETCH_ALIGN_CHECK_EN
    logic exc_hit;
    logic fetch_exc_reg;

    assign exc_hit         = (redirect_pc[1:0] != 2'b00) || (redirect_pc == 32'h0);
    assign redirect_target = exc_hit ? EXC_VECTOR : redirect_pc;
    assign fetch_exc       = fetch_exc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_exc_reg <= 1'b0;
        end else begin
            fetch_exc_reg <= flush && exc_hit;
        end
    end
`else
    assign redirect_target = redirect_pc;
`endif

    assign imem_addr = pc_reg;
    assign halted    = (state_reg == HALTED);
    assign id_valid  = !q_empty;
    assign pop       = id_valid && id_ready;

    assign push_entry.instr = imem_instr;
    assign push_entry.pc    = pc_reg;

    assign id_instr    = head_entry.instr;
    assign id_pc       = head_entry.pc;
    assign id_pc_plus4 = q_empty ? 32'h0 : head_entry.pc + 32'd4;

    always_comb begin
        state_next = state_reg;
        push       = 1'b0;
        flush      = redirect_valid && (state_reg != HALTED);
        case (state_reg)
            // BOOT never pushes: the memory's first read after reset is discarded.
            BOOT: state_next = RUN;
            RUN: begin
                push = ((q_count < DEPTH_CNT) || pop) && !redirect_valid && !halt_req;
                if (halt_req) begin
                    state_next = HALTED;
                end
            end
            default: ;
        endcase
        pc_next = pc_reg;
        if (flush) begin
            pc_next = redirect_target;
        end else if (push) begin
            pc_next = pc_reg + 32'd4;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= BOOT;
            pc_reg    <= RESET_PC;
        end else begin
            state_reg <= state_next;
            pc_reg    <= pc_next;
        end
    end

    fetch_queue #(
        .DEPTH  (FIFO_DEPTH),
        .PTR_W  (PTR_W),
        .DATA_W (64)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .head_data (head_entry),
        .count     (q_count),
        .empty     (q_empty)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: directed stimulus queues expected PCs, a monitor
// checks every accepted decode transaction against a behavioural instruction memory.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt_req;
    logic        id_ready;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
    logic        halted;
`ifdef FETCH_ALIGN_CHECK_EN
    logic        fetch_exc;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_pc;

    function automatic logic [31:0] imem_model(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0 : (a ^ 32'hDEAD_BEEF);
    endfunction

    assign imem_instr = imem_model(imem_addr);

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt_req       (halt_req),
        .id_ready       (id_ready),
        .id_valid       (id_valid),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4),
        .halted         (halted)
`ifdef FETCH_ALIGN_CHECK_EN
        ,
        .fetch_exc      (fetch_exc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted head entry must match the next expected PC.
    always @(negedge clk) begin
        if (rst_n && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_txn: got pc %h expected none", id_pc);
            end else begin
                exp_pc = exp_q.pop_front();
                $display("txn pc=%h instr=%h pc4=%h expected_pc=%h", id_pc, id_instr, id_pc_plus4, exp_pc);
                check("txn_pc", id_pc, exp_pc);
                check("txn_instr", id_instr, imem_model(exp_pc));
                check("txn_pc4", id_pc_plus4, exp_pc + 32'd4);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        halt_req       = 1'b0;
        id_ready       = 1'b1;

        // Sequential fetch, stall, redirect and halt-drain consumption order.
        exp_q = '{32'h0040_0000, 32'h0040_0004, 32'h0040_0008, 32'h0040_000C,
                  32'h0040_0010, 32'h0040_0014, 32'h0040_0040, 32'h0040_0044,
                  32'h0040_0048, 32'h0040_004C};

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("boot_addr", imem_addr, 32'h0040_0000);
        check("boot_valid", id_valid, 1'b0);
        check("boot_halted", halted, 1'b0);
        check("boot_pc", id_pc, 32'h0);
        check("boot_instr", id_instr, 32'h0);
        check("boot_pc4", id_pc_plus4, 32'h0);

        next();
        check("run1_valid", id_valid, 1'b0);
        next();
        check("first_valid", id_valid, 1'b1);
        check("first_pc", id_pc, 32'h0040_0000);
        check("first_addr", imem_addr, 32'h0040_0004);
        next();
        check("seq_pc1", id_pc, 32'h0040_0004);
        next();
        check("seq_pc2", id_pc, 32'h0040_0008);

        next();
        id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            next();
            check("stall_addr", imem_addr, 32'h0040_0014);
            check("stall_pc", id_pc, 32'h0040_000C);
            check("stall_instr", id_instr, imem_model(32'h0040_000C));
            check("stall_valid", id_valid, 1'b1);
        end

        next();
        id_ready = 1'b1;
        next();
        next();
        next();
        check("full_head", id_pc, 32'h0040_0018);
        check("full_addr", imem_addr, 32'h0040_0020);
        id_ready       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0040;

        next();
        redirect_valid = 1'b0;
        id_ready       = 1'b1;
        check("bubble_valid", id_valid, 1'b0);
        check("redir_addr", imem_addr, 32'h0040_0040);
        next();
        check("redir_pc", id_pc, 32'h0040_0040);
        check("redir_pc4", id_pc_plus4, 32'h0040_0044);

        next();
        next();
        id_ready = 1'b0;
        next();
        check("pre_halt_head", id_pc, 32'h0040_0048);
        check("pre_halt_addr", imem_addr, 32'h0040_0050);
        halt_req = 1'b1;
        next();
        halt_req = 1'b0;
        check("halted_set", halted, 1'b1);
        check("halt_addr", imem_addr, 32'h0040_0050);
        next();
        check("halt_addr_frozen", imem_addr, 32'h0040_0050);
        check("halt_valid", id_valid, 1'b1);
        id_ready = 1'b1;
        next();
        next();
        check("drained_valid", id_valid, 1'b0);
        check("drained_halted", halted, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0100;
        next();
        redirect_valid = 1'b0;
        check("halt_ignores_redirect", imem_addr, 32'h0040_0050);
        check("halt_valid_off", id_valid, 1'b0);
        next();
        check("halt_valid_off2", id_valid, 1'b0);

        // Asynchronous reset mid-operation, then redirect together with halt.
        rst_n = 1'b0;
        #1;
        check("async_rst_addr", imem_addr, 32'h0040_0000);
        check("async_rst_halted", halted, 1'b0);
        check("async_rst_valid", id_valid, 1'b0);
        next();
        rst_n = 1'b1;
        next();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0100;
        halt_req       = 1'b1;
        next();
        redirect_valid = 1'b0;
        halt_req       = 1'b0;
        check("rh_halted", halted, 1'b1);
        check("rh_addr", imem_addr, 32'h0040_0100);
        check("rh_valid", id_valid, 1'b0);
        next();
        check("rh_no_push", id_valid, 1'b0);
        check("rh_addr_hold", imem_addr, 32'h0040_0100);

        // Misaligned redirect target.
        rst_n = 1'b0;
        next();
        rst_n = 1'b1;
        next();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0040_0042;
`ifdef FETCH_ALIGN_CHECK_EN
        exp_q.push_back(32'h8000_0180);
`else
        exp_q.push_back(32'h0040_0042);
`endif
        next();
        redirect_valid = 1'b0;
        check("mis_valid", id_valid, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
        check("exc_pulse", fetch_exc, 1'b1);
        check("exc_addr", imem_addr, 32'h8000_0180);
`else
        check("mis_addr", imem_addr, 32'h0040_0042);
`endif
        next();
`ifdef FETCH_ALIGN_CHECK_EN
        check("exc_clear", fetch_exc, 1'b0);
`endif
        check("mis_head_valid", id_valid, 1'b1);
        next();
        id_ready = 1'b0;
        next();
        next();
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
